// File: rtl/array_mult_row_sequencer.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one row of WIDTH full-adder cells
// evaluated once per cycle, shift-and-add style, with valid/ready on both sides.
module array_mult_row_sequencer #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [WIDTH-1:0]              multiplicand_i,
  input  logic [WIDTH-1:0]              multiplier_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [2*WIDTH-1:0]            product_o,
  output logic                          busy_o,
  output logic [$clog2(WIDTH+1)-1:0]    steps_o
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [WIDTH:0]      acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;

  logic [WIDTH-1:0]    rowSum;
  logic                rowCarry;
  logic [2*WIDTH:0]    nextFull;
  logic [2*WIDTH:0]    shifted;
  logic [CW-1:0]       cntNext;
  logic                remZero;
  logic                lastStep;

  // One row evaluation: ripple the carry through the cells, then shift {acc,q} right.
  always_comb begin
    rowCarry = 1'b0;
    rowSum   = '0;
    for (int j = 0; j < WIDTH; j++) begin
      {rowCarry, rowSum[j]} = {1'b0, a_q[j] & q_q[0]} + {1'b0, acc_q[j]} + {1'b0, rowCarry};
    end
    nextFull = {1'b0, rowCarry, rowSum, q_q[WIDTH-1:1]};
    cntNext  = cnt_q + 1'b1;
    remZero  = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if ((i + int'(cnt_q)) <= (WIDTH - 1) && q_q[i]) remZero = 1'b0;
    end
    lastStep = (cntNext == CW'(WIDTH)) || (EARLY_EXIT && remZero);
    // After an early stop the product still sits WIDTH-cnt positions too high.
    shifted  = nextFull >> (CW'(WIDTH) - cntNext);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = multiplicand_i;
          q_d     = multiplier_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        {acc_d, q_d} = nextFull;
        cnt_d        = cntNext;
        if (lastStep) begin
          prod_d  = shifted[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign product_o   = prod_q;
  assign steps_o     = cnt_q;

endmodule

// File: tb/tb_array_mult_row_sequencer.sv
// Bench for array_mult_row_sequencer: instance 0 runs without early exit, instance 1 with it;
// a transaction-level model predicts every output each cycle.
module tb_array_mult_row_sequencer;

  logic             clk;
  logic             rst;
  logic [1:0]       inValid;
  logic [1:0]       inReady;
  logic [1:0][7:0]  aIn;
  logic [1:0][7:0]  bIn;
  logic [1:0]       outValid;
  logic [1:0]       outReady;
  logic [1:0]       dirReady;
  logic [1:0]       rndReady;
  logic             randomMode;
  logic [1:0][15:0] prodOut;
  logic [1:0]       busyOut;
  logic [1:0][3:0]  stepsOut;

  int checks = 0;
  int errors = 0;
  logic cmpEn = 1'b0;

  int          mPhase[2];
  int          mSteps[2];
  int          mLat[2];
  logic [15:0] mProd[2];
  int          handoffs[2];

  array_mult_row_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
    .multiplicand_i(aIn[0]), .multiplier_i(bIn[0]), .out_valid_o(outValid[0]),
    .out_ready_i(outReady[0]), .product_o(prodOut[0]), .busy_o(busyOut[0]),
    .steps_o(stepsOut[0]));

  array_mult_row_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
    .multiplicand_i(aIn[1]), .multiplier_i(bIn[1]), .out_valid_o(outValid[1]),
    .out_ready_i(outReady[1]), .product_o(prodOut[1]), .busy_o(busyOut[1]),
    .steps_o(stepsOut[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outReady = randomMode ? rndReady : dirReady;

  always @(posedge clk) begin
    #1 rndReady = 2'($urandom_range(0, 3));
  end

  function automatic int expectedSteps(input int inst, input logic [7:0] b);
    int n;
    if (inst == 0) return 8;
    n = 1;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted op completes after a computable step count.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mPhase[k] = 0;
        mSteps[k] = 0;
      end else if (mPhase[k] == 0) begin
        if (inValid[k]) begin
          mPhase[k] = 1;
          mSteps[k] = 0;
          mLat[k]   = expectedSteps(k, bIn[k]);
          mProd[k]  = 16'(aIn[k]) * 16'(bIn[k]);
        end
      end else if (mPhase[k] == 1) begin
        mSteps[k]++;
        if (mSteps[k] == mLat[k]) mPhase[k] = 2;
      end else if (outReady[k]) begin
        mPhase[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("in_ready%0d", k), 32'(inReady[k]), 32'(mPhase[k] == 0));
        checkOutput($sformatf("out_valid%0d", k), 32'(outValid[k]), 32'(mPhase[k] == 2));
        checkOutput($sformatf("busy%0d", k), 32'(busyOut[k]), 32'(mPhase[k] != 0));
        checkOutput($sformatf("steps%0d", k), 32'(stepsOut[k]), 32'(mSteps[k]));
        if (mPhase[k] == 2)
          checkOutput($sformatf("product%0d", k), 32'(prodOut[k]), 32'(mProd[k]));
        if (outValid[k] === 1'b1 && outReady[k]) handoffs[k]++;
      end
    end
  end

  task automatic applyStimulus(input int inst, input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    inValid[inst] = 1'b1;
    aIn[inst]     = a;
    bIn[inst]     = b;
    while (inReady[inst] !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    inValid[inst] = 1'b0;
    aIn[inst]     = 8'($urandom);
    bIn[inst]     = 8'($urandom);
  endtask

  task automatic waitDone(input int inst, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (outValid[inst] !== 1'b1 && cycles < 50);
  endtask

  task automatic waitIdle(input int inst);
    int guard = 0;
    while (inReady[inst] !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic runRandom(input int inst, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      applyStimulus(inst, 8'($urandom), 8'($urandom));
    end
    waitIdle(inst);
  endtask

  initial begin
    int lat;
    int h0;
    int h1;
    rst        = 1'b1;
    inValid    = '0;
    aIn        = '0;
    bIn        = '0;
    dirReady   = 2'b11;
    randomMode = 1'b0;
    rndReady   = '0;
    handoffs   = '{0, 0};
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmpEn = 1'b1;
    checkOutput("rst_in_ready", 32'(inReady), 32'h3);
    checkOutput("rst_out_valid", 32'(outValid), 32'h0);
    checkOutput("rst_product", 32'(prodOut[0]), 32'h0);
    checkOutput("rst_steps", 32'(stepsOut[0]), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed: full-scale operands");
    applyStimulus(0, 8'hFF, 8'hFF);
    waitDone(0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd8);
    checkOutput("t1_product", 32'(prodOut[0]), 32'hFE01);
    checkOutput("t1_steps", 32'(stepsOut[0]), 32'd8);

    $display("[TB] directed: zero operands");
    applyStimulus(0, 8'h00, 8'hA5);
    waitDone(0, lat);
    checkOutput("t2a_product", 32'(prodOut[0]), 32'h0);
    checkOutput("t2a_steps", 32'(stepsOut[0]), 32'd8);
    applyStimulus(0, 8'hA5, 8'h00);
    waitDone(0, lat);
    checkOutput("t2b_product", 32'(prodOut[0]), 32'h0);
    checkOutput("t2b_steps", 32'(stepsOut[0]), 32'd8);

    $display("[TB] directed: downstream stall");
    waitIdle(0);
    dirReady[0] = 1'b0;
    applyStimulus(0, 8'h0D, 8'h0B);
    waitDone(0, lat);
    h0 = handoffs[0];
    inValid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_product", 32'(prodOut[0]), 32'h008F);
      checkOutput("t3_hold_in_ready", 32'(inReady[0]), 32'd0);
      @(posedge clk); #1;
    end
    inValid[0] = 1'b0;
    dirReady[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("t3_released", 32'(outValid[0]), 32'd0);
    checkOutput("t3_one_handoff", 32'(handoffs[0] - h0), 32'd1);

    $display("[TB] directed: early exit");
    applyStimulus(1, 8'h03, 8'h05);
    waitDone(1, lat);
    checkOutput("t4a_latency", 32'(lat), 32'd3);
    checkOutput("t4a_product", 32'(prodOut[1]), 32'h000F);
    checkOutput("t4a_steps", 32'(stepsOut[1]), 32'd3);
    applyStimulus(1, 8'h03, 8'h80);
    waitDone(1, lat);
    checkOutput("t4b_product", 32'(prodOut[1]), 32'h0180);
    checkOutput("t4b_steps", 32'(stepsOut[1]), 32'd8);
    applyStimulus(1, 8'h5A, 8'h00);
    waitDone(1, lat);
    checkOutput("t4c_latency", 32'(lat), 32'd1);
    checkOutput("t4c_product", 32'(prodOut[1]), 32'h0);
    checkOutput("t4c_steps", 32'(stepsOut[1]), 32'd1);

    $display("[TB] directed: reset mid-operation");
    waitIdle(0);
    waitIdle(1);
    applyStimulus(0, 8'h7F, 8'h3C);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("t5_steps_before", 32'(stepsOut[0]), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t5_in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("t5_no_valid", 32'(outValid[0]), 32'd0);
    applyStimulus(0, 8'd2, 8'd3);
    waitDone(0, lat);
    checkOutput("t5_next_product", 32'(prodOut[0]), 32'd6);

    $display("[TB] random back-to-back traffic");
    waitIdle(0);
    randomMode = 1'b1;
    h0 = handoffs[0];
    runRandom(0, 1000);
    checkOutput("t6_handoffs0", 32'(handoffs[0] - h0), 32'd1000);
    h1 = handoffs[1];
    runRandom(1, 400);
    checkOutput("t6_handoffs1", 32'(handoffs[1] - h1), 32'd400);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
